// File: rtl/re_name_multi.sv
// ---------------------------------------------------------------------------
// re_name_multi
//
// Register-renaming stage between scoreboard and issue/read-operands. Every
// architectural GPR and FPR owns NR_NAMES physical names. Per register the
// stage keeps the name of the youngest writer (cur_name) and the number of
// issued-but-uncommitted writers (inflight). Issue stalls while every name of
// the destination is in flight; NR_COMMIT_PORTS commit ports release names.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   flush_i                    clear all rename state
//   flush_unissued_instr_i     suppress the table update of this handshake
//   issue_valid_i/ready_o      handshake with the scoreboard
//   rs1/rs2/rs3/rd_*_i         architectural operands of the instruction
//   issue_valid_o/ack_i        handshake with the issue stage
//   rs1/rs2/rs3/rd_addr_o      renamed operands {name, arch}
//   commit_valid/rd/fpr_i      per-port release of one renamed writer
// ---------------------------------------------------------------------------
module re_name_multi #(
  parameter int unsigned NR_ARCH_REGS    = 32,
  parameter int unsigned NR_NAMES        = 4,
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned ENABLE_RENAME   = 1,
  localparam int unsigned AW = $clog2(NR_ARCH_REGS),
  localparam int unsigned NW = $clog2(NR_NAMES)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          flush_unissued_instr_i,
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  logic [AW-1:0]                 rs1_addr_i,
  input  logic [AW-1:0]                 rs2_addr_i,
  input  logic                          rs1_fpr_i,
  input  logic                          rs2_fpr_i,
  input  logic [AW-1:0]                 rs3_addr_i,
  input  logic                          rs3_valid_i,
  input  logic [AW-1:0]                 rd_addr_i,
  input  logic                          rd_fpr_i,
  input  logic                          rd_valid_i,
  output logic                          issue_valid_o,
  input  logic                          issue_ack_i,
  output logic [NW+AW-1:0]              rs1_addr_o,
  output logic [NW+AW-1:0]              rs2_addr_o,
  output logic [NW+AW-1:0]              rs3_addr_o,
  output logic [NW+AW-1:0]              rd_addr_o,
  input  logic [NR_COMMIT_PORTS-1:0]    commit_valid_i,
  input  logic [NR_COMMIT_PORTS*AW-1:0] commit_rd_i,
  input  logic [NR_COMMIT_PORTS-1:0]    commit_fpr_i
);

  localparam int unsigned IW = $clog2(NR_NAMES + 1);
  localparam bit          EN = (ENABLE_RENAME != 0);

  // Index 0 = GPR file, index 1 = FPR file.
  logic [NW-1:0] cur_name_q [2][NR_ARCH_REGS];
  logic [NW-1:0] cur_name_d [2][NR_ARCH_REGS];
  logic [IW-1:0] inflight_q [2][NR_ARCH_REGS];
  logic [IW-1:0] inflight_d [2][NR_ARCH_REGS];

  logic rd_is_x0;
  logic stall;
  logic alloc;
  logic over_commit;

  logic [NW-1:0] rs1_name, rs2_name, rs3_name, rd_name;

  // GPR x0 is hard-wired zero: never renamed, never stalls.
  assign rd_is_x0 = !rd_fpr_i && (rd_addr_i == '0);

  assign stall = EN && rd_valid_i && !rd_is_x0
                 && (inflight_q[rd_fpr_i][rd_addr_i] == IW'(NR_NAMES));

  // Gating with rst_ni keeps both handshake outputs low while in reset.
  assign issue_valid_o = rst_ni && issue_valid_i && !stall;
  assign issue_ready_o = rst_ni && issue_ack_i && !stall;

  assign alloc = issue_valid_i && issue_ack_i && !stall && rd_valid_i
                 && !flush_unissued_instr_i && !rd_is_x0;

  // Source lookups read registered state only: a writer allocated this cycle
  // becomes visible to readers in the next cycle.
  assign rs1_name = EN ? cur_name_q[rs1_fpr_i][rs1_addr_i] : '0;
  assign rs2_name = EN ? cur_name_q[rs2_fpr_i][rs2_addr_i] : '0;
  assign rs3_name = (EN && rs3_valid_i) ? cur_name_q[1][rs3_addr_i] : '0;
  // The destination gets the name after the youngest one; NR_NAMES is a
  // power of two so the NW-bit add wraps naturally.
  assign rd_name  = (EN && rd_valid_i && !rd_is_x0)
                    ? cur_name_q[rd_fpr_i][rd_addr_i] + NW'(1) : '0;

  assign rs1_addr_o = {rs1_name, rs1_addr_i};
  assign rs2_addr_o = {rs2_name, rs2_addr_i};
  assign rs3_addr_o = {rs3_name, rs3_addr_i};
  assign rd_addr_o  = {rd_name,  rd_addr_i};

  // Next-state tables: allocation adds one, each commit-port hit removes one.
  always_comb begin
    // NOTE: every target gets a default before any conditional update, so no
    // path through the block leaves a value unassigned and no latch is inferred.
    cur_name_d  = cur_name_q;
    inflight_d  = inflight_q;
    over_commit = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < int'(NR_ARCH_REGS); r++) begin
        int  hits;
        int  net;
        logic alloc_here;
        hits = 0;
        for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
          if (commit_valid_i[k] && (commit_fpr_i[k] == (f == 1))
              && (commit_rd_i[k*AW +: AW] == AW'(r)))
            hits = hits + 1;
        end
        // Commits to GPR x0 carry no rename and are dropped.
        if (f == 0 && r == 0) hits = 0;
        alloc_here = alloc && (rd_fpr_i == (f == 1)) && (rd_addr_i == AW'(r));
        if (hits > int'(inflight_q[f][r])) over_commit = 1'b1;
        net = int'(inflight_q[f][r]) + (alloc_here ? 1 : 0) - hits;
        // Saturate: an illegal over-commit bottoms out at 0, and with renaming
        // disabled (no stall) the count tops out at NR_NAMES.
        if (net < 0) net = 0;
        if (net > int'(NR_NAMES)) net = int'(NR_NAMES);
        inflight_d[f][r] = IW'(net);
        if (alloc_here) cur_name_d[f][r] = cur_name_q[f][r] + NW'(1);
      end
    end
  end

  // NOTE: the tables are reset (asynchronously) rather than left as plain
  // storage, because a reset mid-operation must drop every outstanding name.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int f = 0; f < 2; f++) begin
        for (int r = 0; r < int'(NR_ARCH_REGS); r++) begin
          cur_name_q[f][r] <= '0;
          inflight_q[f][r] <= '0;
        end
      end
    end else if (flush_i) begin
      // Flush overrides any allocation or commit in the same cycle.
      for (int f = 0; f < 2; f++) begin
        for (int r = 0; r < int'(NR_ARCH_REGS); r++) begin
          cur_name_q[f][r] <= '0;
          inflight_q[f][r] <= '0;
        end
      end
    end else begin
      // NOTE: state updates use non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      cur_name_q <= cur_name_d;
      inflight_q <= inflight_d;
    end
  end

  // Releasing more writers than are outstanding points at a commit-side bug.
  assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i) !over_commit)
    else $error("re_name_multi: commit to register with no writer in flight");

endmodule

// File: doc/re_name_multi.md
Name: re_name_multi

Overview:
Parametrised register-renaming stage between the scoreboard and issue/read-operands. Each architectural GPR and FPR can have NR_NAMES physical names instead of a single toggle bit. The stage tracks outstanding (issued, uncommitted) writers per architectural register. It stalls issue when every name of the destination is in flight, and frees names through NR_COMMIT_PORTS commit ports.

Parameters:
NR_ARCH_REGS, 32, architectural registers per file; power of two; AW = $clog2(NR_ARCH_REGS)
NR_NAMES, 4, names per architectural register; power of two, >=2; NW = $clog2(NR_NAMES)
NR_COMMIT_PORTS, 2, number of parallel commit/free ports
ENABLE_RENAME, 1, 0 = all name fields forced to 0, no stall, tables still maintained

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  clear all rename state
flush_unissued_instr_i  in  1  suppress the table update for the current handshake
issue_valid_i  in  1  instruction valid from scoreboard
issue_ready_o  out  1  handshake accepted, to scoreboard
rs1_addr_i, rs2_addr_i  in  AW  source addresses
rs1_fpr_i, rs2_fpr_i  in  1  source reads the FP file
rs3_addr_i  in  AW  third source, always FPR
rs3_valid_i  in  1  rs3 is a real operand
rd_addr_i  in  AW  destination address
rd_fpr_i  in  1  destination is in the FP file
rd_valid_i  in  1  instruction writes rd
issue_valid_o  out  1  valid to issue stage
issue_ack_i  in  1  issue stage accepts
rs1_addr_o, rs2_addr_o, rs3_addr_o, rd_addr_o  out  NW+AW  renamed addresses {name, arch}
commit_valid_i  in  NR_COMMIT_PORTS  per-port commit of a renamed writer
commit_rd_i  in  NR_COMMIT_PORTS*AW  committed architectural rd
commit_fpr_i  in  NR_COMMIT_PORTS  committed rd is an FPR

Behaviour:
- State per file (GPR and FPR), per register:
  - cur_name, NW bits: name of the youngest writer.
  - inflight, $clog2(NR_NAMES+1) bits: number of outstanding writers.
  - Both reset to 0.
- Stall (combinational) = ENABLE_RENAME & rd_valid_i & !(GPR & rd==0) & inflight[rd] == NR_NAMES.
- issue_valid_o = issue_valid_i & !stall.
- issue_ready_o = issue_ack_i & !stall.
- Both outputs are 0 during reset. The issue stage never asserts issue_ack_i without issue_valid_o.
- Source names: rsX_addr_o = {ENABLE_RENAME ? cur_name_q[file][rsX] : 0, rsX_addr_i}.
  - When rs3_valid_i=0, rs3_addr_o = {0, rs3_addr_i}.
  - Lookups use _q state, so there is no same-cycle bypass.
- rd_addr_o:
  - rd_valid_i=1: {cur_name_q[file][rd] + 1 (mod NR_NAMES, natural wrap), rd}.
  - GPR x0 or rd_valid_i=0: {0, rd}.
- Allocation event = issue_valid_i & issue_ack_i & !stall & rd_valid_i & !flush_unissued_instr_i & !(GPR & rd==0).
  - On an allocation event the next cycle has cur_name += 1 (wrap) and inflight += 1.
- Commit, per port k with commit_valid_i[k]: inflight[file][commit_rd] -= 1.
  - Commits to GPR x0 are ignored.
  - Several ports naming the same register decrement by the number of hits.
  - Committing a register with inflight==0 is illegal: assertion; the counter saturates at 0.
- Allocation and commit to the same register in the same cycle: net change = +1 - hits. cur_name still advances.
- All latencies are 1 cycle: the table update is visible to the lookup in the following cycle.
- flush_i: next state is all cur_name=0 and all inflight=0. flush_i has priority over any allocation or commit in the same cycle.
- GPR x0 is never renamed. Its cur_name and inflight stay 0.
- Reset mid-operation clears both tables asynchronously. Outputs follow combinationally from the cleared state.
- ENABLE_RENAME=0: name fields are 0, stall is 0, tables are still updated (aids debug).

Test Plan:
- Reset, then issue rd=x5 GPR, rs1=x5 with ack -> rd_addr_o={1,5}, rs1_addr_o={0,5}. Next cycle rs1=x5 -> {1,5}, inflight[5]=1.
- 4 issues to f3, no commits (NR_NAMES=4) -> rd names 1,2,3,0. 5th issue -> issue_valid_o=0, issue_ready_o=0. Commit f3 -> 5th issues with rd name 1.
- rd=x0 issued 10 times -> rd_addr_o={0,0}, never stalls, inflight[0] stays 0.
- Ack with flush_unissued_instr_i=1 on rd=x7 -> cur_name[7] and inflight[7] unchanged.
- Both commit ports hit x9 (inflight 2) while a new x9 allocation occurs -> inflight[9]=1, cur_name advanced by 1.
- flush_i with concurrent issue and commit -> all tables 0 next cycle. After release, rs1=x5 -> {0,5}.
